my_fsm_run_detector: RTL and testbench

//   Moore-type run detector on a serial 1-bit input stream.
//   - Asserts out while the most recent RUN_LEN samples of in, taken on clock

---
 rtl/my_fsm_run_detector.sv | 80 ++++++++
 tb/tb_my_fsm_run_detector.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/my_fsm_run_detector.sv
// my_fsm_run_detector
//   Moore run detector: out is high while the last RUN_LEN samples of in were 1.
//   The state is a binary count of consecutive ones, saturating at the detect state.
//   Optional feature macro: MY_FSM_MATCH_CNT_EN adds match_cnt, a saturating count
//   of detect-state entries (once per run, not once per cycle).
module my_fsm_run_detector #(
    parameter int RUN_LEN = 2,
    parameter int CNT_W   = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             in,
    output logic             out
`ifdef MY_FSM_MATCH_CNT_EN
    ,
    output logic [CNT_W-1:0] match_cnt
`endif
);

    // Sk: the last k samples were 1 and the one before was 0 (or reset).
    typedef enum logic [3:0] {
        S0,  S1,  S2,  S3,  S4,  S5,  S6,  S7,
        S8,  S9,  S10, S11, S12, S13, S14, S15
    } state_t;

    localparam state_t S_DET = state_t'(RUN_LEN[3:0]);

    // Reject parameter values the 4-bit state or the counter cannot represent.
    if (RUN_LEN < 1 || RUN_LEN > 15 || CNT_W < 1) begin : g_bad_param
        $error("my_fsm_run_detector: RUN_LEN must be 1..15 and CNT_W >= 1");
    end

    state_t state;
    state_t next_state;

    // State register; reset discards any partial run.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state <= S0;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic: a 0 always returns to S0; a 1 advances toward the detect
    // state and holds there. Encodings above S_DET behave as S0.
    always_comb begin
        next_state = S0;
        if (in) begin
            if (state == S_DET) begin
                next_state = S_DET;
            end else if (state < S_DET) begin
                next_state = state_t'(state + 4'd1);
            end else begin
                next_state = S1;
            end
        end
    end

    // Output is decoded from the state register only, so in never reaches out
    // combinationally.
    assign out = (state == S_DET);

`ifdef MY_FSM_MATCH_CNT_EN
    logic enter_det;

    // A run is counted on the single edge where the detect state is entered.
    assign enter_det = (next_state == S_DET) && (state != S_DET);

    // Saturating run counter, cleared by reset.
    always_ff @(posedge clock) begin
        if (!reset) begin
            match_cnt <= '0;
        end else if (enter_det && (match_cnt != {CNT_W{1'b1}})) begin
            match_cnt <= match_cnt + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_my_fsm_run_detector.sv
// tb_my_fsm_run_detector
//   Three detectors (RUN_LEN 1, 2, 3) share one input stream and reset. The
//   reference model tracks the length of the current run of ones since the last
//   0 or reset; a detector of length L must show out = (run >= L), and its match
//   count goes up when the run length reaches exactly L, saturating at its width.
module tb_my_fsm_run_detector;

    logic clock = 1'b0;
    logic reset = 1'b1;
    logic in    = 1'b0;
    logic out1, out2, out3;

    int comparisons = 0;
    int failures    = 0;

    // Reference model state.
    int run = 0;
    int lens [3] = '{1, 2, 3};
    int cmax [3] = '{255, 3, 255};
    int mc   [3] = '{0, 0, 0};

`ifdef MY_FSM_MATCH_CNT_EN
    logic [7:0] cnt1;
    logic [1:0] cnt2;
    logic [7:0] cnt3;

    my_fsm_run_detector #(.RUN_LEN(1), .CNT_W(8)) dut1 (
        .clock(clock), .reset(reset), .in(in), .out(out1), .match_cnt(cnt1));
    my_fsm_run_detector #(.RUN_LEN(2), .CNT_W(2)) dut2 (
        .clock(clock), .reset(reset), .in(in), .out(out2), .match_cnt(cnt2));
    my_fsm_run_detector #(.RUN_LEN(3), .CNT_W(8)) dut3 (
        .clock(clock), .reset(reset), .in(in), .out(out3), .match_cnt(cnt3));
`else
    my_fsm_run_detector #(.RUN_LEN(1), .CNT_W(8)) dut1 (
        .clock(clock), .reset(reset), .in(in), .out(out1));
    my_fsm_run_detector #(.RUN_LEN(2), .CNT_W(2)) dut2 (
        .clock(clock), .reset(reset), .in(in), .out(out2));
    my_fsm_run_detector #(.RUN_LEN(3), .CNT_W(8)) dut3 (
        .clock(clock), .reset(reset), .in(in), .out(out3));
`endif

    // Clock
    always #5 clock = ~clock;

    // Drive one sample on the falling edge, let one rising edge pass, update the
    // model for that edge, then settle 1 time unit before any sampling.
    task automatic drive_edge(input logic b, input logic rn);
        @(negedge clock);
        in    = b;
        reset = rn;
        @(posedge clock);
        if (!rn) begin
            run = 0;
            for (int i = 0; i < 3; i++) mc[i] = 0;
        end else if (b) begin
            if (run < 100) run++;
            for (int i = 0; i < 3; i++)
                if (run == lens[i] && mc[i] < cmax[i]) mc[i]++;
        end else begin
            run = 0;
        end
        #1;
    endtask

    function automatic logic [2:0] model_outs();
        return {run >= 3, run >= 2, run >= 1};
    endfunction

    task automatic test_reset();
        logic [2:0] obs;
        drive_edge(1'b0, 1'b0);
        obs = {out3, out2, out1};
        comparisons++;
        if (obs !== 3'b000) begin
            failures++;
            $display("FAIL reset_out: got %b expected 000", obs);
        end
`ifdef MY_FSM_MATCH_CNT_EN
        comparisons++;
        if ({cnt1, cnt2, cnt3} !== 18'd0) begin
            failures++;
            $display("FAIL reset_cnt: got %0d/%0d/%0d expected 0/0/0", cnt1, cnt2, cnt3);
        end
`endif
        // Reset must also win over in=1.
        drive_edge(1'b1, 1'b0);
        obs = {out3, out2, out1};
        comparisons++;
        if (obs !== 3'b000) begin
            failures++;
            $display("FAIL reset_over_in: got %b expected 000", obs);
        end
    endtask

    task automatic test_sequence();
        logic seq   [5] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
        logic exp_o [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        drive_edge(1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            drive_edge(seq[i], 1'b1);
            comparisons++;
            if (out2 !== exp_o[i]) begin
                failures++;
                $display("FAIL seq_10111 step %0d: got %b expected %b", i, out2, exp_o[i]);
            end
        end
    endtask

    task automatic test_rise_fall();
        logic seq   [3] = '{1'b1, 1'b1, 1'b0};
        logic exp_o [3] = '{1'b0, 1'b1, 1'b0};
        drive_edge(1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            drive_edge(seq[i], 1'b1);
            comparisons++;
            if (out2 !== exp_o[i]) begin
                failures++;
                $display("FAIL rise_fall step %0d: got %b expected %b", i, out2, exp_o[i]);
            end
        end
    endtask

    task automatic test_reset_mid_run();
        drive_edge(1'b0, 1'b0);
        drive_edge(1'b1, 1'b1);
        drive_edge(1'b1, 1'b1);
        comparisons++;
        if (out2 !== 1'b1) begin
            failures++;
            $display("FAIL mid_run_detect: got %b expected 1", out2);
        end
        drive_edge(1'b1, 1'b0);
        comparisons++;
        if ({out3, out2, out1} !== 3'b000) begin
            failures++;
            $display("FAIL mid_run_reset: got %b expected 000", {out3, out2, out1});
        end
        drive_edge(1'b1, 1'b1);
        comparisons++;
        if ({out2, out1} !== 2'b01) begin
            failures++;
            $display("FAIL mid_run_first1: got %b expected 01", {out2, out1});
        end
        drive_edge(1'b1, 1'b1);
        comparisons++;
        if (out2 !== 1'b1) begin
            failures++;
            $display("FAIL mid_run_second1: got %b expected 1", out2);
        end
    endtask

    task automatic test_run_len3();
        logic seq   [6] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
        logic exp_o [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        drive_edge(1'b0, 1'b0);
        for (int i = 0; i < 6; i++) begin
            drive_edge(seq[i], 1'b1);
            comparisons++;
            if (out3 !== exp_o[i]) begin
                failures++;
                $display("FAIL run_len3 step %0d: got %b expected %b", i, out3, exp_o[i]);
            end
        end
    endtask

    task automatic test_len1_delay();
        logic b;
        drive_edge(1'b0, 1'b0);
        for (int i = 0; i < 20; i++) begin
            b = 1'($urandom_range(0, 1));
            drive_edge(b, 1'b1);
            comparisons++;
            if (out1 !== b) begin
                failures++;
                $display("FAIL len1_delay step %0d: got %b expected %b", i, out1, b);
            end
        end
    endtask

`ifdef MY_FSM_MATCH_CNT_EN
    task automatic test_saturation();
        drive_edge(1'b0, 1'b0);
        for (int r = 0; r < 5; r++) begin
            drive_edge(1'b1, 1'b1);
            drive_edge(1'b1, 1'b1);
            drive_edge(1'b0, 1'b1);
        end
        comparisons++;
        if (cnt2 !== 2'd3) begin
            failures++;
            $display("FAIL cnt_saturate: got %0d expected 3", cnt2);
        end
        comparisons++;
        if (cnt1 !== 8'd5 || cnt3 !== 8'd0) begin
            failures++;
            $display("FAIL cnt_other_lens: got %0d/%0d expected 5/0", cnt1, cnt3);
        end
    endtask
`endif

    task automatic test_random();
        logic b, rn;
        logic [2:0] exp_v;
        drive_edge(1'b0, 1'b0);
        for (int i = 0; i < 400; i++) begin
            b  = ($urandom_range(0, 3) != 0);
            rn = ($urandom_range(0, 31) != 0);
            drive_edge(b, rn);
            exp_v = model_outs();
            comparisons++;
            if ({out3, out2, out1} !== exp_v) begin
                failures++;
                $display("FAIL random_out step %0d: got %b expected %b", i, {out3, out2, out1}, exp_v);
            end
`ifdef MY_FSM_MATCH_CNT_EN
            comparisons++;
            if (int'(cnt1) != mc[0] || int'(cnt2) != mc[1] || int'(cnt3) != mc[2]) begin
                failures++;
                $display("FAIL random_cnt step %0d: got %0d/%0d/%0d expected %0d/%0d/%0d",
                         i, cnt1, cnt2, cnt3, mc[0], mc[1], mc[2]);
            end
`endif
        end
    endtask

    initial begin
        test_reset();
        test_sequence();
        test_rise_fall();
        test_reset_mid_run();
        test_run_len3();
        test_len1_delay();
`ifdef MY_FSM_MATCH_CNT_EN
        test_saturation();
`endif
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", comparisons, failures);
        $finish;
    end

endmodule
